// File: rtl/sqrt_arbiter_if.sv
// sqrt_arbiter_if: requester bus and square-root unit handshake bundled for sqrt_arbiter.
// Rev 1.0
`default_nettype none

interface sqrt_arbiter_if #(
  parameter int N     = 4,
  parameter int WIDTH = 36
);
  localparam int IDX_W = $clog2(N);

  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] rad;
  logic [N-1:0]       done;
  logic [WIDTH-1:0]   res_root;
  logic               res_err;
  logic [IDX_W-1:0]   grant_idx;
  logic               arb_busy;
  logic               sq_start;
  logic [WIDTH-1:0]   sq_rad;
  logic               sq_busy;
  logic               sq_valid;
  logic [WIDTH-1:0]   sq_root;

  // Arbiter side.
  modport slave (
    input  req, rad, sq_busy, sq_valid, sq_root,
    output done, res_root, res_err, grant_idx, arb_busy, sq_start, sq_rad
  );

  // Requesters plus square-root unit side.
  modport master (
    output req, rad, sq_busy, sq_valid, sq_root,
    input  done, res_root, res_err, grant_idx, arb_busy, sq_start, sq_rad
  );
endinterface

`default_nettype wire

// File: rtl/sqrt_arbiter.sv
// sqrt_arbiter: round-robin sharing of one iterative square-root unit, with a hang watchdog.
// Rev 1.0
`default_nettype none

module sqrt_arbiter #(
  parameter int N       = 4,
  parameter int WIDTH   = 36,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  sqrt_arbiter_if.slave bus
);
  localparam int IDX_W = $clog2(N);
  localparam int WD_W  = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] last_grant, last_grant_nxt;
  logic [IDX_W-1:0] grant, grant_nxt;
  logic [IDX_W-1:0] cand, sel_idx;
  logic             sel_found;
  logic [WIDTH-1:0] sq_rad_q, sq_rad_nxt;
  logic [WIDTH-1:0] res_root_q, res_root_nxt;
  logic             sq_start_q, sq_start_nxt;
  logic             res_err_q, res_err_nxt;
  logic             arb_busy_q, arb_busy_nxt;
  logic [N-1:0]     done_q, done_nxt;
  logic [WD_W-1:0]  wd, wd_nxt;
  logic             saw_busy, saw_busy_nxt;
  logic             valid_q;
  logic             accept;

  // First requester above the last one served, wrapping modulo N.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % N);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // A level valid left over from an earlier operation must not be taken as
  // this operation's result: accept only after busy was seen, or on a fresh rise.
  assign accept = bus.sq_valid && !bus.sq_busy && (saw_busy || !valid_q);

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    grant_nxt      = grant;
    sq_rad_nxt     = sq_rad_q;
    sq_start_nxt   = 1'b0;
    done_nxt       = '0;
    res_root_nxt   = res_root_q;
    res_err_nxt    = res_err_q;
    wd_nxt         = wd;
    saw_busy_nxt   = saw_busy;

    case (state)
      S_IDLE: begin
        if (sel_found && !bus.sq_busy) begin
          grant_nxt    = sel_idx;
          sq_rad_nxt   = bus.rad[sel_idx*WIDTH +: WIDTH];
          saw_busy_nxt = 1'b0;
          wd_nxt       = '0;
          sq_start_nxt = 1'b1;
          state_nxt    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        wd_nxt = wd + 1'b1;
        if (bus.sq_busy) begin
          saw_busy_nxt = 1'b1;
        end
        if (accept) begin
          res_root_nxt    = bus.sq_root;
          res_err_nxt     = 1'b0;
          done_nxt[grant] = 1'b1;
          state_nxt       = S_DONE;
        end else if (wd == WD_LAST) begin
          res_root_nxt    = '0;
          res_err_nxt     = 1'b1;
          done_nxt[grant] = 1'b1;
          state_nxt       = S_DONE;
        end
      end
      S_DONE: begin
        last_grant_nxt = grant;
        state_nxt      = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    arb_busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      last_grant <= LAST_IDX;
      grant      <= '0;
      sq_rad_q   <= '0;
      sq_start_q <= 1'b0;
      done_q     <= '0;
      res_root_q <= '0;
      res_err_q  <= 1'b0;
      arb_busy_q <= 1'b0;
      wd         <= '0;
      saw_busy   <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      grant      <= grant_nxt;
      sq_rad_q   <= sq_rad_nxt;
      sq_start_q <= sq_start_nxt;
      done_q     <= done_nxt;
      res_root_q <= res_root_nxt;
      res_err_q  <= res_err_nxt;
      arb_busy_q <= arb_busy_nxt;
      wd         <= wd_nxt;
      saw_busy   <= saw_busy_nxt;
      valid_q    <= bus.sq_valid;
    end
  end

  assign bus.done      = done_q;
  assign bus.res_root  = res_root_q;
  assign bus.res_err   = res_err_q;
  assign bus.grant_idx = grant;
  assign bus.arb_busy  = arb_busy_q;
  assign bus.sq_start  = sq_start_q;
  assign bus.sq_rad    = sq_rad_q;

endmodule

`default_nettype wire

// File: tb/tb_sqrt_arbiter.sv
// tb_sqrt_arbiter: directed vector table plus hand sequences for timeout, stale valid and reset.
// Rev 1.0
`default_nettype none

module tb_sqrt_arbiter;
  localparam int N   = 4;
  localparam int W   = 36;
  localparam int TO  = 64;
  localparam int LAT = 18;
  localparam int M_NORMAL = 0;
  localparam int M_DEAD   = 1;
  localparam int M_MANUAL = 2;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;

  sqrt_arbiter_if #(.N(N), .WIDTH(W)) bus ();

  sqrt_arbiter #(.N(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks     = 0;
  int failures   = 0;
  int start_hi   = 0;
  int busy_start = 0;
  int mode       = M_NORMAL;

  // Square-root unit stand-in: busy for LAT cycles starting the cycle after
  // it sees start, then a one-cycle valid with busy low.
  logic          m_busy  = 1'b0;
  logic          m_valid = 1'b0;
  logic          m_armed = 1'b0;
  logic [W-1:0]  m_root  = '0;
  logic [W-1:0]  m_lat   = '0;
  int            m_cnt   = 0;
  logic          man_busy  = 1'b0;
  logic          man_valid = 1'b0;
  logic [W-1:0]  man_root  = '0;

  function automatic logic [W-1:0] isqrt(input logic [W-1:0] x);
    longint r;
    r = 0;
    for (int b = 17; b >= 0; b--) begin
      longint t;
      t = r | (longint'(1) << b);
      if (t * t <= longint'(x)) r = t;
    end
    return r[W-1:0];
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b0;
    if (bus.sq_start && mode == M_NORMAL) begin
      m_armed <= 1'b1;
      m_lat   <= bus.sq_rad;
    end
    if (m_armed) begin
      m_armed <= 1'b0;
      m_busy  <= 1'b1;
      m_cnt   <= LAT - 1;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b1;
        m_root  <= isqrt(m_lat);
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  assign bus.sq_busy  = (mode == M_MANUAL) ? man_busy  : (mode == M_DEAD) ? 1'b0 : m_busy;
  assign bus.sq_valid = (mode == M_MANUAL) ? man_valid : (mode == M_DEAD) ? 1'b0 : m_valid;
  assign bus.sq_root  = (mode == M_MANUAL) ? man_root  : m_root;

  always @(negedge clk) begin
    if (bus.sq_start) start_hi <= start_hi + 1;
    if (bus.sq_start && bus.sq_busy) busy_start <= busy_start + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ctrl"}, {55'd0, bus.done, bus.res_err, bus.grant_idx, bus.arb_busy, bus.sq_start}, 64'd0);
    check({pfx, "_res_root"}, {28'd0, bus.res_root}, 64'd0);
    check({pfx, "_sq_rad"}, {28'd0, bus.sq_rad}, 64'd0);
  endtask

  task automatic set_rad(input int i, input logic [W-1:0] v);
    bus.rad[i*W +: W] = v;
  endtask

  // Drive a request mask and check the next done strobe it produces.
  task automatic run_op(input string name, input logic [3:0] mask, input int exp_idx,
                        input logic [W-1:0] exp_root, input logic exp_err, output int waited);
    logic [3:0] exp_done;
    exp_done = 4'b0001 << exp_idx;
    bus.req = mask;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (bus.done == '0 && waited < 300);
    check({name, "_done"}, {60'd0, bus.done}, {60'd0, exp_done});
    check({name, "_root"}, {28'd0, bus.res_root}, {28'd0, exp_root});
    check({name, "_err"}, {63'd0, bus.res_err}, {63'd0, exp_err});
    check({name, "_grant"}, {62'd0, bus.grant_idx}, 64'(exp_idx));
  endtask

  typedef struct {
    logic [3:0] req;
    int         exp_idx;
    logic [W-1:0] exp_root;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #200000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    int w;
    int cnt;
    int s0;
    logic seen;

    // rad = {9, 4, 1, 0} gives root == requester index.
    tbl[0]  = '{4'b1000, 3, 36'd3};
    tbl[1]  = '{4'b1111, 0, 36'd0};
    tbl[2]  = '{4'b1111, 1, 36'd1};
    tbl[3]  = '{4'b1111, 2, 36'd2};
    tbl[4]  = '{4'b1111, 3, 36'd3};
    tbl[5]  = '{4'b1111, 0, 36'd0};
    tbl[6]  = '{4'b1000, 3, 36'd3};
    tbl[7]  = '{4'b1001, 0, 36'd0};
    tbl[8]  = '{4'b1001, 3, 36'd3};
    tbl[9]  = '{4'b0110, 1, 36'd1};
    tbl[10] = '{4'b0110, 2, 36'd2};

    bus.req = '0;
    bus.rad = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    // Single request, latency and one-cycle start.
    set_rad(1, 36'd144);
    s0 = start_hi;
    run_op("single", 4'b0010, 1, 36'd12, 1'b0, w);
    check("single_latency", 64'(w - 1), 64'd21);
    check("single_sq_rad", {28'd0, bus.sq_rad}, 64'd144);
    bus.req = '0;
    @(negedge clk);
    check("single_idle_busy", {63'd0, bus.arb_busy}, 64'd0);
    check("single_done_strobe", {60'd0, bus.done}, 64'd0);
    check("single_start_cycles", 64'(start_hi - s0), 64'd1);

    // Hung unit: watchdog abort, then the pending requester.
    mode = M_DEAD;
    bus.req = 4'b0110;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.sq_start && w < 20);
    cnt = 1;
    do begin
      @(negedge clk);
      cnt++;
    end while (bus.done == '0 && cnt < 200);
    check("to_latency", 64'(cnt), 64'(TO + 2));
    check("to_done", {60'd0, bus.done}, 64'b0100);
    check("to_err", {63'd0, bus.res_err}, 64'd1);
    check("to_root", {28'd0, bus.res_root}, 64'd0);
    mode = M_NORMAL;
    run_op("after_to", 4'b0010, 1, 36'd12, 1'b0, w);

    set_rad(0, 36'd0);
    set_rad(1, 36'd1);
    set_rad(2, 36'd4);
    set_rad(3, 36'd9);
    for (int i = 0; i < 11; i++) begin
      run_op($sformatf("rr%0d", i), tbl[i].req, tbl[i].exp_idx, tbl[i].exp_root, 1'b0, w);
    end

    // Valid held high before the operation must not complete it.
    mode      = M_MANUAL;
    man_busy  = 1'b0;
    man_valid = 1'b1;
    man_root  = 36'd999;
    bus.req   = '0;
    repeat (3) @(negedge clk);
    set_rad(0, 36'd1000000);
    bus.req = 4'b0001;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (bus.done != '0) seen = 1'b1;
    end
    check("stale_no_done", {63'd0, seen}, 64'd0);
    check("stale_still_busy", {63'd0, bus.arb_busy}, 64'd1);
    set_rad(0, 36'd7);
    man_valid = 1'b0;
    man_busy  = 1'b1;
    repeat (3) @(negedge clk);
    man_busy  = 1'b0;
    man_valid = 1'b1;
    man_root  = 36'd1000;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (bus.done == '0 && w < 100);
    check("fresh_done", {60'd0, bus.done}, 64'b0001);
    check("fresh_root", {28'd0, bus.res_root}, 64'd1000);
    check("fresh_err", {63'd0, bus.res_err}, 64'd0);
    check("fresh_rad_latched", {28'd0, bus.sq_rad}, 64'd1000000);
    man_valid = 1'b0;
    mode      = M_NORMAL;
    set_rad(0, 36'd1000000);

    // Reset while waiting on the unit.
    bus.req = 4'b0100;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.sq_start && w < 20);
    repeat (3) @(negedge clk);
    check("midwait_busy", {63'd0, bus.arb_busy}, 64'd1);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("midwait_reset");
    bus.req = '0;
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.done != '0) seen = 1'b1;
    end
    check("midwait_no_done", {63'd0, seen}, 64'd0);
    reset_n = 1'b1;
    run_op("post_reset", 4'b1001, 0, 36'd1000, 1'b0, w);
    bus.req = '0;
    repeat (2) @(negedge clk);

    check("start_while_busy", 64'(busy_start), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
